io_ports: RTL and testbench
===========================

# io_ports

Parametrised input/output port bank between the CPU datapath and board I/O: switches, keys and LEDs/7-segment drivers. It replaces the fixed four-in/four-out port block. The CPU reads any input port and writes any output port by port ID. New behaviour over the fixed block:
- per-port input synchronisation;
- sticky change flags with a maskable interrupt;
- read-modify-write output modes (set, clear, toggle).

## Interface
- DATA_W, 8, width of every port
- NUM_IN, 4, number of input ports (1..2**ID_W)
- NUM_OUT, 4, number of output ports (1..2**ID_W)
- ID_W, 2, width of port IDs
- OUT_RST, 0, reset value of every output register (DATA_W bits)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  NUM_IN*DATA_W  raw external inputs, port i at bits [i*DATA_W +: DATA_W], asynchronous to clk
- rd_en  in  1  CPU read strobe
- rd_id  in  ID_W  input port selected for read
- rd_data  out  DATA_W  synchronised value of port rd_id
- wr_en  in  1  CPU write strobe
- wr_id  in  ID_W  output port selected for write
- wr_mode  in  2  00 load, 01 set bits (OR), 10 clear bits (AND NOT), 11 toggle (XOR)
- wr_data  in  DATA_W  write operand
- out_data  out  NUM_OUT*DATA_W  output registers, same packing as in_data
- irq_mask  in  NUM_IN  per-port interrupt enable
- chg_flags  out  NUM_IN  sticky per-port change flags
- irq  out  1  OR of (chg_flags & irq_mask)

## Operation
- **Input path.** Each input port passes through a two-stage synchroniser, sync1 then sync2, each DATA_W bits. rd_data is a combinational mux of sync2[rd_id].
- **Out-of-range read.** If rd_id >= NUM_IN, rd_data = 0 and no flag changes.
- **Priming.** A 2-bit prime counter counts edges after reset release and saturates at 2. Change detection is enabled only while the counter = 2. This prevents spurious flags from the reset-to-first-sample transition.
- **Change detection.** When enabled, on each edge flag[i] is set if sync1[i] != sync2[i], i.e. any bit of port i is about to change.
- **Flag clear.** On an edge with rd_en = 1 and rd_id = i < NUM_IN, flag[i] is cleared.
- **Set and clear on the same edge.** Set wins; the flag stays 1 so the new change is not lost.
- **Output write.** On an edge with wr_en = 1 and wr_id < NUM_OUT, out[wr_id] is updated according to wr_mode:
  - 00: out <= wr_data
  - 01: out <= out | wr_data
  - 10: out <= out & ~wr_data
  - 11: out <= out ^ wr_data
- **Out-of-range write.** If wr_id >= NUM_OUT, the write is ignored. All other output registers always hold their value.
- **Concurrent access.** Reads and writes are independent and may occur on the same edge.
- **irq.** Combinational from the flag registers and irq_mask; no extra latency.
- **Width rules.** No arithmetic. All operations are bitwise on DATA_W bits, with no carry or width growth.

## Timing
- **Reset (asynchronous, immediate).**
  - sync1 = sync2 = 0, flags = 0, prime counter = 0
  - every output register = OUT_RST
  - rd_data = 0 (sync2 = 0), chg_flags = 0, irq = 0
- **Input latency.** Input stable before edge N: sync1 captures at N, sync2 at N+1. rd_data reflects the value after edge N+1; flag[i] sets at edge N+1 (if detection is enabled).
- **Priming.** The counter reaches 2 after the 2nd edge following rst deassertion. The first edge that can set a flag is the 3rd.
- **Write latency.** out_data updates at the write edge, visible one cycle after the strobe. Back-to-back writes to the same port compound, e.g. set then toggle.
- **Reset mid-operation.** Asserting rst overrides any pending write, read clear or flag set at once. After release, priming restarts from 0.
- **No handshake.** Strobes are single-cycle qualifiers; holding rd_en high on port i keeps flag[i] clear except in cycles where a new change arrives.

## Test plan
- **Reset and priming.** Assert rst with in_data = 0xA5 on all ports, release it, then wait 4 edges. Required: rd_data(rd_id=0) = 0xA5 after the 2nd edge, chg_flags = 0 throughout, irq = 0, out_data = OUT_RST on all ports.
- **Change flag and irq.** With the bank primed and port 2 changed 0x00 -> 0x3C, irq_mask = 0100. Required: chg_flags[2] = 1 and irq = 1 two edges after the change. A read of port 2 clears the flag at the next edge; irq then drops to 0.
- **Set/clear collision.** Toggle port 1 input so that the flag-set edge coincides with rd_en, rd_id = 1. Required: flag[1] stays 1.
- **Write modes on port 3.** Load 0xF0, set 0x0F, clear 0x81, toggle 0xFF. Required: out[3] = 0xF0, then 0xFF, then 0x7E, then 0x81. Other ports are unchanged throughout.
- **Out-of-range access.** With NUM_IN = 3, NUM_OUT = 3, read id 3 and write id 3 with 0x55. Required: rd_data = 0, out_data and flags unchanged.
- **Reset during activity.** Assert rst in the same cycle as wr_en with wr_data = 0x12 to port 0. Required: out[0] = OUT_RST, and no flags are set for 2 edges after release.

Source files
------------

// File: rtl/io_ports.sv
// io_ports: parametrised I/O port bank between the CPU datapath and board I/O.
// Inputs pass through a two-flop synchroniser, raise sticky change flags (with a
// maskable interrupt) once priming after reset completes, and are read by port ID.
// Outputs are registers written by port ID with load/set/clear/toggle modes.
module io_ports #(
  parameter int                DATA_W  = 8,
  parameter int                NUM_IN  = 4,
  parameter int                NUM_OUT = 4,
  parameter int                ID_W    = 2,
  parameter logic [DATA_W-1:0] OUT_RST = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*DATA_W-1:0]    in_data,
  input  logic                        rd_en,
  input  logic [ID_W-1:0]             rd_id,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        wr_en,
  input  logic [ID_W-1:0]             wr_id,
  input  logic [1:0]                  wr_mode,
  input  logic [DATA_W-1:0]           wr_data,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  input  logic [NUM_IN-1:0]           irq_mask,
  output logic [NUM_IN-1:0]           chg_flags,
  output logic                        irq
);

  localparam logic [1:0] PRIMED = 2'd2;

  logic [DATA_W-1:0] sync1_q [NUM_IN];
  logic [DATA_W-1:0] sync1_d [NUM_IN];
  logic [DATA_W-1:0] sync2_q [NUM_IN];
  logic [DATA_W-1:0] sync2_d [NUM_IN];
  logic [NUM_IN-1:0] flag_q;
  logic [NUM_IN-1:0] flag_d;
  logic [1:0]        prime_q;
  logic [1:0]        prime_d;
  logic [DATA_W-1:0] out_q [NUM_OUT];
  logic [DATA_W-1:0] out_d [NUM_OUT];

  // Read-modify-write operator for output registers; purely bitwise.
  function automatic logic [DATA_W-1:0] apply_mode(input logic [DATA_W-1:0] cur,
                                                   input logic [1:0]        mode,
                                                   input logic [DATA_W-1:0] opnd);
    case (mode)
      2'b00:   return opnd;
      2'b01:   return cur | opnd;
      2'b10:   return cur & ~opnd;
      default: return cur ^ opnd;
    endcase
  endfunction

  // Synchroniser next state, priming counter and sticky flag update (set beats clear).
  always_comb begin
    prime_d = prime_q;
    if (prime_q != PRIMED) prime_d = prime_q + 2'd1;
    flag_d = flag_q;
    for (int i = 0; i < NUM_IN; i++) begin
      sync1_d[i] = in_data[i*DATA_W +: DATA_W];
      sync2_d[i] = sync1_q[i];
      if (rd_en && (rd_id == ID_W'(i))) flag_d[i] = 1'b0;
      if ((prime_q == PRIMED) && (sync1_q[i] != sync2_q[i])) flag_d[i] = 1'b1;
    end
  end

  // Input-side state: synchroniser stages, flags and priming counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
      end
      flag_q  <= '0;
      prime_q <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync1_q[i] <= sync1_d[i];
        sync2_q[i] <= sync2_d[i];
      end
      flag_q  <= flag_d;
      prime_q <= prime_d;
    end
  end

  // Output register next state; out-of-range IDs match no port and are ignored.
  always_comb begin
    for (int j = 0; j < NUM_OUT; j++) begin
      out_d[j] = out_q[j];
      if (wr_en && (wr_id == ID_W'(j))) out_d[j] = apply_mode(out_q[j], wr_mode, wr_data);
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_OUT; j++) out_q[j] <= OUT_RST;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) out_q[j] <= out_d[j];
    end
  end

  // Read mux over synchronised inputs; unmatched IDs read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (rd_id == ID_W'(i)) rd_data = sync2_q[i];
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign out_data[j*DATA_W +: DATA_W] = out_q[j];
  end

  assign chg_flags = flag_q;
  assign irq       = |(flag_q & irq_mask);

endmodule

// File: tb/tb_io_ports.sv
// Bench for io_ports: a 4-in/4-out bank for the main sequence and a 3-in/3-out
// bank for out-of-range IDs. Expected values are queued when stimulus is applied
// and popped when the corresponding output is sampled.
module tb_io_ports;
  localparam logic [7:0] RSTV = 8'h5A;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        rd_en, wr_en;
  logic [1:0]  rd_id, wr_id, wr_mode;
  logic [7:0]  wr_data, rd_data;
  logic [31:0] out_data;
  logic [3:0]  irq_mask, chg_flags;
  logic        irq;

  logic        s_rd_en, s_wr_en;
  logic [1:0]  s_rd_id, s_wr_id, s_wr_mode;
  logic [7:0]  s_wr_data, s_rd_data;
  logic [23:0] s_out_data;
  logic [2:0]  s_irq_mask, s_chg_flags;
  logic        s_irq;

  io_ports #(.DATA_W(8), .NUM_IN(4), .NUM_OUT(4), .ID_W(2), .OUT_RST(RSTV)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data),
    .wr_en(wr_en), .wr_id(wr_id), .wr_mode(wr_mode), .wr_data(wr_data),
    .out_data(out_data), .irq_mask(irq_mask), .chg_flags(chg_flags), .irq(irq)
  );

  io_ports #(.DATA_W(8), .NUM_IN(3), .NUM_OUT(3), .ID_W(2), .OUT_RST(8'h00)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]),
    .rd_en(s_rd_en), .rd_id(s_rd_id), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_id(s_wr_id), .wr_mode(s_wr_mode), .wr_data(s_wr_data),
    .out_data(s_out_data), .irq_mask(s_irq_mask), .chg_flags(s_chg_flags), .irq(s_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_data = {4{8'hA5}};
    rd_en = 0; rd_id = 0; wr_en = 0; wr_id = 0; wr_mode = 0; wr_data = 0; irq_mask = 4'hF;
    s_rd_en = 0; s_rd_id = 0; s_wr_en = 0; s_wr_id = 0; s_wr_mode = 0; s_wr_data = 0;
    s_irq_mask = 3'b111;
    #1 rst = 1'b1;
    #1;
    push("rst_rd_data", 32'h0);        pop_chk({24'h0, rd_data});
    push("rst_flags", 32'h0);          pop_chk({28'h0, chg_flags});
    push("rst_irq", 32'h0);            pop_chk({31'h0, irq});
    push("rst_out", {4{RSTV}});        pop_chk(out_data);
    step(); step();
    rst = 1'b0;

    // Priming: data visible after the 2nd edge, never a flag.
    for (int k = 1; k <= 4; k++) begin
      push("prime_rd_data", (k >= 2) ? 32'hA5 : 32'h0);
      push("prime_flags", 32'h0);
      push("prime_irq", 32'h0);
      step();
      pop_chk({24'h0, rd_data});
      pop_chk({28'h0, chg_flags});
      pop_chk({31'h0, irq});
    end
    push("prime_out", {4{RSTV}});      pop_chk(out_data);

    // Out-of-range access on the 3-port bank.
    s_wr_en = 1; s_wr_id = 0; s_wr_mode = 2'b00; s_wr_data = 8'h11;
    push("oor_inrange_rd", 32'hA5);
    step();
    pop_chk({24'h0, s_rd_data});
    s_wr_id = 3; s_wr_data = 8'h55; s_rd_en = 1; s_rd_id = 3;
    push("oor_rd_data", 32'h0);
    push("oor_out", 32'h000011);
    push("oor_flags", 32'h0);
    step();
    pop_chk({24'h0, s_rd_data});
    pop_chk({8'h0, s_out_data});
    pop_chk({29'h0, s_chg_flags});
    s_wr_en = 0; s_rd_en = 0;

    // Port 2 to 0x00 while reading it continuously: flag only where a change lands.
    irq_mask = 4'b0100;
    in_data[23:16] = 8'h00; rd_en = 1; rd_id = 2;
    step();
    push("p2_hold_b_flags", 32'h4);
    push("p2_hold_b_rd", 32'h00);
    step();
    pop_chk({28'h0, chg_flags});
    pop_chk({24'h0, rd_data});
    push("p2_hold_c_flags", 32'h0);
    step();
    pop_chk({28'h0, chg_flags});
    rd_en = 0;

    // Port 2 change 0x00 -> 0x3C.
    in_data[23:16] = 8'h3C;
    push("chg_e1_flags", 32'h0);
    push("chg_e1_irq", 32'h0);
    step();
    pop_chk({28'h0, chg_flags});
    pop_chk({31'h0, irq});
    push("chg_e2_flags", 32'h4);
    push("chg_e2_irq", 32'h1);
    push("chg_e2_rd", 32'h3C);
    step();
    pop_chk({28'h0, chg_flags});
    pop_chk({31'h0, irq});
    pop_chk({24'h0, rd_data});
    irq_mask = 4'b0000;
    push("irq_masked", 32'h0);
    #1 pop_chk({31'h0, irq});
    irq_mask = 4'b0100;
    push("irq_unmasked", 32'h1);
    #1 pop_chk({31'h0, irq});
    rd_en = 1;
    push("clr_flags", 32'h0);
    push("clr_irq", 32'h0);
    step();
    pop_chk({28'h0, chg_flags});
    pop_chk({31'h0, irq});
    rd_en = 0;

    // Set/clear collision on port 1.
    in_data[15:8] = 8'h5A;
    push("col_e1_flags", 32'h0);
    step();
    pop_chk({28'h0, chg_flags});
    rd_en = 1; rd_id = 1;
    push("col_e2_flags", 32'h2);
    step();
    pop_chk({28'h0, chg_flags});
    push("col_e3_flags", 32'h0);
    step();
    pop_chk({28'h0, chg_flags});

    // Write modes on port 3 with a concurrent read of port 0.
    rd_id = 0;
    wr_en = 1; wr_id = 3;
    wr_mode = 2'b00; wr_data = 8'hF0;
    push("wr_load", {8'hF0, RSTV, RSTV, RSTV});
    push("wr_load_rd", 32'hA5);
    step();
    pop_chk(out_data);
    pop_chk({24'h0, rd_data});
    wr_mode = 2'b01; wr_data = 8'h0F;
    push("wr_set", {8'hFF, RSTV, RSTV, RSTV});
    step();
    pop_chk(out_data);
    wr_mode = 2'b10; wr_data = 8'h81;
    push("wr_clear", {8'h7E, RSTV, RSTV, RSTV});
    step();
    pop_chk(out_data);
    wr_mode = 2'b11; wr_data = 8'hFF;
    push("wr_toggle", {8'h81, RSTV, RSTV, RSTV});
    step();
    pop_chk(out_data);
    wr_en = 0; rd_en = 0;
    push("wr_hold", {8'h81, RSTV, RSTV, RSTV});
    step();
    pop_chk(out_data);
    wr_en = 1; wr_id = 0; wr_mode = 2'b01; wr_data = 8'h0F;
    push("wr_set_p0", {8'h81, RSTV, RSTV, 8'h5F});
    step();
    pop_chk(out_data);

    // Reset asserted together with a write to port 0.
    wr_mode = 2'b00; wr_data = 8'h12; irq_mask = 4'hF;
    rst = 1'b1;
    push("rstact_out", {4{RSTV}});
    push("rstact_rd", 32'h0);
    #1;
    pop_chk(out_data);
    pop_chk({24'h0, rd_data});
    push("rstact_edge_out", {4{RSTV}});
    step();
    pop_chk(out_data);
    rst = 1'b0; wr_en = 0;
    for (int k = 1; k <= 3; k++) begin
      push("rel_flags", 32'h0);
      push("rel_irq", 32'h0);
      push("rel_rd", (k >= 2) ? 32'hA5 : 32'h0);
      step();
      pop_chk({28'h0, chg_flags});
      pop_chk({31'h0, irq});
      pop_chk({24'h0, rd_data});
    end
    push("rel_out", {4{RSTV}});
    pop_chk(out_data);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
